seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Display end of the stopwatch digit counter. Captures four BCD digits (MM:SS), time-multiplexes them
//  onto a 4-digit common-anode 7-segment display, and blinks the digit pair being adjusted.
//  Sits between the counter and the board pins; blink phase comes from the clock divider's blink output.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot; >=4 (100 MHz -> 1 kHz/digit)
//  GUARD        2       cycles at the start of each slot with all anodes off (anti-ghost); < REFRESH_DIV
//  LZ_BLANK     0       1: blank digit 3 when its value is 0
//  DP_POS       2       digit index whose DP is lit (separator after minutes units)
// PORTS
//  clk        in   1  system clock
//  RESET_N    in   1  asynchronous, active-low reset
//  LOAD       in   1  capture strobe for D0..D3; sampled every clk
//  D0         in   4  seconds units (BCD)
//  D1         in   4  seconds tens
//  D2         in   4  minutes units
//  D3         in   4  minutes tens
//  BLINK_EN   in   1  adjust mode active
//  BLINK_SEL  in   1  0: blink D1:D0, 1: blink D3:D2
//  BLINK_PH   in   1  blink phase level, async to clk; 1 = dark phase
//  AN         out  4  anodes, active-low, AN[i] drives digit i
//  SEG        out  7  cathodes, active-low, {g,f,e,d,c,b,a}
//  DP         out  1  decimal point, active-low
//  SCAN_IDX   out  2  digit index of current slot
// BEHAVIOUR
//  Reset (async, RESET_N=0): AN=4'hF, SEG=7'h7F, DP=1, SCAN_IDX=0, shadow digits=0, slot counter=0,
//   guard counter=0, blink synchronizer=0. Effect is immediate, independent of clk.
//  Capture: LOAD=1 at a clk edge -> shadow[3:0] <= D3..D0. LOAD held high captures every cycle.
//   D inputs are ignored while LOAD=0.
//  Slot counter: 0..REFRESH_DIV-1, +1 per clk. At REFRESH_DIV-1: counter <= 0, SCAN_IDX <= SCAN_IDX+1
//   (wraps 3->0), guard counter <= GUARD. Otherwise the guard counter decrements to 0 and holds.
//  BLINK_PH passes through a 2-FF synchronizer -> bp_s (2-cycle latency).
//  Digit i = SCAN_IDX is dark when any of these holds:
//   guard counter != 0;
//   BLINK_EN=1 & bp_s=1 & i is in the pair selected by BLINK_SEL;
//   LZ_BLANK=1 & i==3 & shadow[3]==0.
//  Outputs are registered, 1 clk after their sources (SCAN_IDX, guard, shadow, bp_s):
//   dark:  AN <= 4'hF, SEG <= 7'h7F, DP <= 1
//   lit:   AN <= ~(4'b1 << i), SEG <= dec(shadow[i]), DP <= (i==DP_POS) ? 0 : 1
//  dec() active-low codes: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex).
//   Values A-F display a dash: 7'h3F.
//  First slot after reset release: SCAN_IDX=0, no guard, so AN=4'hE from the 1st clk after release.
//  Simultaneous LOAD and slot change: the new slot displays the newly loaded value.
//  Never more than one AN bit low at a time.
// TESTING  (bench build: REFRESH_DIV=8, GUARD=2)
//  Reset: RESET_N=0 mid-cycle -> AN=F, SEG=7F, DP=1 with no clk edge. Release, LOAD D3..D0=1,2,3,4 ->
//   per 8-cycle slot: 2 cycles AN=F, then AN=E/SEG=19, D/30, B/24 with DP=0, 7/79. Wraps to E.
//  Invalid BCD: D0=4'hC loaded -> in slot 0, SEG=3F and AN=E.
//  Blink: BLINK_EN=1, BLINK_SEL=1, BLINK_PH=1 held -> from the 3rd clk on, AN[3:2] never low.
//   Slots 0/1 unchanged. BLINK_PH=0 -> digits 2/3 return. BLINK_EN=0 -> BLINK_PH has no effect.
//  LZ_BLANK=1 build: D3=0 -> AN[3] stays 1 in slot 3. D3=5 -> slot 3 shows AN=7, SEG=12.
//  Mid-slot LOAD: in slot 1 pulse LOAD with D1=9 -> SEG changes to 10 on the next clk and AN stays D.
//  Reset mid-scan: RESET_N low during slot 2 -> outputs dark immediately. After release SCAN_IDX=0
//   and the full slot timing restarts from counter 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: captures MM:SS BCD digits and time-multiplexes them onto a 4-digit common-anode display
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter bit LZ_BLANK    = 1'b0,
    parameter int DP_POS      = 2
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       LOAD,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    input  logic       BLINK_EN,
    input  logic       BLINK_SEL,
    input  logic       BLINK_PH,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [1:0] SCAN_IDX
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    logic [CW-1:0]     cnt;
    logic [GW-1:0]     guard;
    logic [3:0][3:0]   shadow;
    logic              bp_m, bp_s;
    logic [3:0]        cur;
    logic [6:0]        seg_nx;
    logic              dark, slot_end;
    always_comb begin
        cur      = shadow[SCAN_IDX];
        slot_end = cnt == CW'(REFRESH_DIV - 1);
        dark     = guard != '0
                || (BLINK_EN && bp_s && SCAN_IDX[1] == BLINK_SEL)
                || (LZ_BLANK && SCAN_IDX == 2'd3 && shadow[3] == 4'd0);
        case (cur)
            4'd0:    seg_nx = 7'h40;
            4'd1:    seg_nx = 7'h79;
            4'd2:    seg_nx = 7'h24;
            4'd3:    seg_nx = 7'h30;
            4'd4:    seg_nx = 7'h19;
            4'd5:    seg_nx = 7'h12;
            4'd6:    seg_nx = 7'h02;
            4'd7:    seg_nx = 7'h78;
            4'd8:    seg_nx = 7'h00;
            4'd9:    seg_nx = 7'h10;
            default: seg_nx = 7'h3F;
        endcase
    end
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt      <= '0;
            guard    <= '0;
            shadow   <= '0;
            bp_m     <= 1'b0;
            bp_s     <= 1'b0;
            SCAN_IDX <= 2'd0;
            AN       <= 4'hF;
            SEG      <= 7'h7F;
            DP       <= 1'b1;
        end else begin
            cnt      <= slot_end ? '0 : cnt + 1'b1;
            SCAN_IDX <= slot_end ? SCAN_IDX + 2'd1 : SCAN_IDX;
            guard    <= slot_end ? GW'(GUARD) : (guard != '0 ? guard - 1'b1 : guard);
            shadow   <= LOAD ? {D3, D2, D1, D0} : shadow;
            bp_m     <= BLINK_PH;
            bp_s     <= bp_m;
            // outputs follow the registered sources by one cycle, so a new slot starts dark for GUARD cycles
            AN       <= dark ? 4'hF : ~(4'b1 << SCAN_IDX);
            SEG      <= dark ? 7'h7F : seg_nx;
            DP       <= dark || SCAN_IDX != 2'(DP_POS);
        end
    end
endmodule
